// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, class codes and fetch FSM encodings.
// Used by the instr_fetch slice (optional IFETCH_HALT_DETECT_EN lives in instr_fetch.sv).
package cpu_pkg;

  localparam int INSTR_WIDTH = 20;
  localparam int ADDR_BITS   = 5;

  localparam int CLASS_MSB  = 19;
  localparam int CLASS_LSB  = 18;
  localparam int DST_MSB    = 17;
  localparam int DST_LSB    = 16;
  localparam int SRC1_MSB   = 15;
  localparam int SRC1_LSB   = 14;
  localparam int SRC2_MSB   = 13;
  localparam int SRC2_LSB   = 12;
  localparam int OFFSET_MSB = 11;
  localparam int OFFSET_LSB = 4;
  localparam int OP_MSB     = 3;
  localparam int OP_LSB     = 0;

  localparam logic [1:0] CLS_NOP   = 2'b00;
  localparam logic [1:0] CLS_STD   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_FETCH  = 4'b0010,
    ST_HOLD   = 4'b0100,
    ST_HALTED = 4'b1000
  } fetch_state_t;

  function automatic logic [1:0] instr_class(input logic [INSTR_WIDTH-1:0] word);
    return word[CLASS_MSB:CLASS_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus between the fetch stage (slave) and its controller / control unit (master).
// Handshake: instr/pc are meaningful while instr_valid=1 and stay stable until the master
// pulses advance or jump_en for one cycle; a pulse is accepted only while instr_valid=1.
interface instr_fetch_if;
  import cpu_pkg::*;

  logic                   prog_we;
  logic [ADDR_BITS-1:0]   prog_addr;
  logic [INSTR_WIDTH-1:0] prog_data;
  logic                   start;
  logic                   advance;
  logic                   jump_en;
  logic [ADDR_BITS-1:0]   jump_addr;
  logic [INSTR_WIDTH-1:0] instr;
  logic                   instr_valid;
  logic [ADDR_BITS-1:0]   pc;
  logic                   halted;

  modport master (
    output prog_we, prog_addr, prog_data, start, advance, jump_en, jump_addr,
    input  instr, instr_valid, pc, halted
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, advance, jump_en, jump_addr,
    output instr, instr_valid, pc, halted
  );

endinterface

// File: rtl/instr_rom.sv
// Writable program memory: synchronous write port, registered read port.
// A write and a read to the same address on one edge return the written data.
module instr_rom
  import cpu_pkg::*;
#(
  parameter int AW = ADDR_BITS,
  parameter int DW = INSTR_WIDTH
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, fetch FSM and registered instruction output feeding the CU.
// Define IFETCH_HALT_DETECT_EN to stop fetching on class-00 (NOP) words.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_BITS-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.slave  bus,
  output fetch_state_t  state_dbg
);

  fetch_state_t           state;
  logic [ADDR_BITS-1:0]   pc_q;
  logic [ADDR_BITS-1:0]   pc_next;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [INSTR_WIDTH-1:0] rom_q;
  logic                   valid_q;
  logic                   halted_q;
  logic                   rom_we;
  logic                   go_halt;

  // The ROM is addressed with the next PC so its registered read is ready in FETCH.
  always_comb begin
    rom_we  = 1'b0;
    pc_next = pc_q;
    case (state)
      ST_IDLE, ST_HALTED: begin
        rom_we = bus.prog_we;
        if (bus.start) pc_next = RESET_PC;
      end
      ST_HOLD: begin
        if (bus.jump_en)      pc_next = bus.jump_addr;
        else if (bus.advance) pc_next = pc_q + 1'b1;
      end
      default: ;
    endcase
  end

`ifdef IFETCH_HALT_DETECT_EN
  always_comb go_halt = (instr_class(rom_q) == CLS_NOP);
`else
  always_comb go_halt = 1'b0;
`endif

  instr_rom u_rom (
    .clk     (clk),
    .we      (rom_we),
    .wr_addr (bus.prog_addr),
    .wr_data (bus.prog_data),
    .rd_addr (pc_next),
    .rd_data (rom_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            pc_q  <= pc_next;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          instr_q <= rom_q;
          if (go_halt) begin
            halted_q <= 1'b1;
            state    <= ST_HALTED;
          end else begin
            valid_q <= 1'b1;
            state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.jump_en || bus.advance) begin
            pc_q    <= pc_next;
            valid_q <= 1'b0;
            state   <= ST_FETCH;
          end
        end
        ST_HALTED: begin
          if (bus.start) begin
            pc_q     <= pc_next;
            halted_q <= 1'b0;
            state    <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.halted      = halted_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic against a behavioural model,
// with a scoreboard queue checked by an independent monitor.
module tb_instr_fetch;
  import cpu_pkg::*;

`ifdef IFETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam int TB_RESET_PC = 0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  fetch_state_t state_dbg;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(5'(TB_RESET_PC))) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Reference model: memory image, current PC, and whether a word is being presented.
  logic [19:0] m_mem [32];
  int          m_pc   = TB_RESET_PC;
  bit          m_hold = 1'b0;
  logic [25:0] exp_q [$];   // {halt, pc, instr}

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_word();
    int lat;
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      lat++;
      if (bus.instr_valid || bus.halted) break;
    end
    check("latency", lat, 2);
  endtask

  // One cycle of stimulus; the model decides whether a fetch must follow.
  task automatic drive(input bit we, input logic [4:0] wa, input logic [19:0] wd,
                       input bit s, input bit a, input bit j, input logic [4:0] ja);
    bit          fetch;
    bit          h;
    logic [19:0] w;
    fetch = 1'b0;
    if (we && !m_hold) m_mem[wa] = wd;
    if (!m_hold) begin
      if (s) begin m_pc = TB_RESET_PC; fetch = 1'b1; end
    end else if (j) begin
      m_pc = int'(ja); fetch = 1'b1;
    end else if (a) begin
      m_pc = (m_pc + 1) % 32; fetch = 1'b1;
    end
    bus.prog_we = we; bus.prog_addr = wa; bus.prog_data = wd;
    bus.start = s; bus.advance = a; bus.jump_en = j; bus.jump_addr = ja;
    tick();
    bus.prog_we = 1'b0; bus.start = 1'b0; bus.advance = 1'b0; bus.jump_en = 1'b0;
    if (fetch) begin
      w = m_mem[m_pc];
      h = HALT_EN && (w[19:18] == CLS_NOP);
      exp_q.push_back({h, 5'(m_pc), w});
      m_hold = !h;
      wait_word();
      tick();
    end else begin
      repeat (2) tick();
    end
  endtask

  task automatic write(input logic [4:0] a, input logic [19:0] d);
    drive(1'b1, a, d, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr"},  bus.instr, 0);
    check({tag, "_valid"},  bus.instr_valid, 0);
    check({tag, "_pc"},     bus.pc, TB_RESET_PC);
    check({tag, "_halted"}, bus.halted, 0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    check("async_rst_state", state_dbg, ST_IDLE);
    m_hold = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  // Monitor: every newly presented word (or halt) is checked against the queue head.
  logic        pv = 1'b0;
  logic        ph = 1'b0;
  logic [25:0] e;
  always @(negedge clk) begin
    if (!rst) begin
      pv = 1'b0;
      ph = 1'b0;
    end else begin
      if ((bus.instr_valid && !pv) || (bus.halted && !ph)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got instr %h pc %0d, no word was expected", bus.instr, bus.pc);
        end else begin
          e = exp_q.pop_front();
          check("sb_instr",  bus.instr, e[19:0]);
          check("sb_pc",     bus.pc, e[24:20]);
          check("sb_halted", bus.halted, e[25]);
          check("sb_valid",  bus.instr_valid, !e[25]);
        end
      end
      pv = bus.instr_valid;
      ph = bus.halted;
    end
  end

  initial begin
    logic [19:0] held;
    int          op;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.start = 1'b0; bus.advance = 1'b0; bus.jump_en = 1'b0; bus.jump_addr = '0;

    // Reset and idle with no start
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_reset_outputs("idle");
    end
    tick();

    // Sequential fetch
    write(5'd0, 20'h4_1231);
    write(5'd1, 20'h8_A054);
    write(5'd2, 20'hC_B063);
    write(5'd3, 20'h0_0000);
    write(5'd31, 20'h5_5AA1);
    drive(1'b0, 5'd0, 20'h0, 1'b1, 1'b0, 1'b0, 5'd0);
    drive(1'b0, 5'd0, 20'h0, 1'b0, 1'b1, 1'b0, 5'd0);

    // Jump beats advance, then wrap 31 -> 0
    drive(1'b0, 5'd0, 20'h0, 1'b0, 1'b1, 1'b1, 5'd31);
    drive(1'b0, 5'd0, 20'h0, 1'b0, 1'b1, 1'b0, 5'd0);

    // Hold stability, ignored write and ignored start while holding
    held = m_mem[m_pc];
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_instr", bus.instr, held);
      check("hold_pc",    bus.pc, m_pc);
      check("hold_valid", bus.instr_valid, 1);
    end
    tick();
    drive(1'b1, 5'(m_pc), 20'hF_FFFF, 1'b0, 1'b0, 1'b0, 5'd0);
    drive(1'b0, 5'd0, 20'h0, 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    check("hold_we_instr", bus.instr, held);
    check("hold_start_pc", bus.pc, m_pc);
    tick();
    drive(1'b0, 5'd0, 20'h0, 1'b0, 1'b0, 1'b1, 5'(m_pc));

    // Asynchronous reset while holding; memory survives
    async_reset();
    drive(1'b0, 5'd0, 20'h0, 1'b1, 1'b0, 1'b0, 5'd0);

    // Class-00 word at address 3
    repeat (3) drive(1'b0, 5'd0, 20'h0, 1'b0, 1'b1, 1'b0, 5'd0);
    @(negedge clk);
    check("nop_halted", bus.halted, HALT_EN);
    check("nop_valid",  bus.instr_valid, !HALT_EN);
    check("nop_instr",  bus.instr, 20'h0_0000);
    tick();

    // Random traffic on a fresh random program
    async_reset();
    for (int a = 0; a < 32; a++) write(5'(a), 20'($urandom));
    drive(1'b1, 5'(TB_RESET_PC), 20'($urandom), 1'b1, 1'b0, 1'b0, 5'd0);
    for (int n = 0; n < 120; n++) begin
      if (!m_hold) begin
        drive(1'b0, 5'd0, 20'h0, 1'b0, 1'b1, 1'b1, 5'($urandom_range(0, 31)));
        drive(1'b1, 5'($urandom_range(0, 31)), 20'($urandom), 1'b1, 1'b0, 1'b0, 5'd0);
      end else begin
        op = $urandom_range(0, 9);
        if (op <= 4)
          drive(1'b0, 5'd0, 20'h0, 1'b0, 1'b1, 1'b0, 5'd0);
        else if (op <= 6)
          drive(1'b0, 5'd0, 20'h0, 1'b0, 1'b0, 1'b1, 5'($urandom_range(0, 31)));
        else if (op == 7)
          drive(1'b0, 5'd0, 20'h0, 1'b0, 1'b1, 1'b1, 5'($urandom_range(0, 31)));
        else if (op == 8)
          drive(1'b1, 5'($urandom_range(0, 31)), 20'($urandom), 1'b0, 1'b0, 1'b0, 5'd0);
        else
          repeat ($urandom_range(1, 4)) tick();
      end
    end

    repeat (3) tick();
    check("queue_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
